gf_sched: RTL and testbench



---
 rtl/gf_sched_if.sv | 32 +++
 rtl/gf_sched.sv | 152 +++++++++++++++
 tb/tb_gf_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gf_sched_if.sv
// gf_sched_if: requester, engine and response signals shared by the fence-engine scheduler
interface gf_sched_if #(
  parameter int N_REQ = 2,
  parameter int CW    = 10,
  parameter int AW    = 25
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             pt_valid;
  logic [CW-1:0]    pt_x;
  logic [CW-1:0]    pt_y;
  logic             eng_in_valid;
  logic [CW-1:0]    eng_in_x;
  logic [CW-1:0]    eng_in_y;
  logic             eng_out_valid;
  logic [CW-1:0]    eng_out_x;
  logic [CW-1:0]    eng_out_y;
  logic [AW-1:0]    eng_out_area;
  logic [N_REQ-1:0] rsp_valid;
  logic [CW-1:0]    rsp_x;
  logic [CW-1:0]    rsp_y;
  logic [AW-1:0]    rsp_area;
  logic             busy;
  modport slave (
    input  req, pt_valid, pt_x, pt_y, eng_out_valid, eng_out_x, eng_out_y, eng_out_area,
    output gnt, eng_in_valid, eng_in_x, eng_in_y, rsp_valid, rsp_x, rsp_y, rsp_area, busy
  );
  modport master (
    output req, pt_valid, pt_x, pt_y, eng_out_valid, eng_out_x, eng_out_y, eng_out_area,
    input  gnt, eng_in_valid, eng_in_x, eng_in_y, rsp_valid, rsp_x, rsp_y, rsp_area, busy
  );
endinterface

// File: rtl/gf_sched.sv
// gf_sched: round-robin scheduler sharing one fence engine among N_REQ requesters; GF_SCHED_STATS_EN adds per-requester job counters
module gf_sched #(
  parameter int N_REQ = 2,
  parameter int CW    = 10,
  parameter int AW    = 25,
  parameter int GAP   = 2
) (
  input logic        clk,
  input logic        rst_n,
  gf_sched_if.slave  bus
`ifdef GF_SCHED_STATS_EN
  ,
  output logic [8*N_REQ-1:0] job_cnt
`endif
);
  localparam int LW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [2:0] {IDLE, GRANT, LOAD, SEND, WAIT, RET, COOL} state_t;
  state_t           r_state;
  logic [LW-1:0]    r_owner;
  logic [LW-1:0]    r_last;
  logic [LW-1:0]    w_win;
  logic [LW-1:0]    w_idx;
  logic [2:0]       r_wcnt;
  logic [2:0]       r_scnt;
  logic [2:0]       r_rcnt;
  logic [GW-1:0]    r_cool;
  logic [CW-1:0]    r_buf_x [0:5];
  logic [CW-1:0]    r_buf_y [0:5];
  logic [N_REQ-1:0] r_gnt;
  logic             r_eng_in_valid;
  logic [CW-1:0]    r_eng_in_x;
  logic [CW-1:0]    r_eng_in_y;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [CW-1:0]    r_rsp_x;
  logic [CW-1:0]    r_rsp_y;
  logic [AW-1:0]    r_rsp_area;
  // round-robin winner: scan from last+1 upward with wrap, the nearest requester wins
  always_comb begin
    w_win = r_last;
    w_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = LW'((int'(r_last) + i) % N_REQ);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end
  // point buffer, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (r_state == LOAD && bus.pt_valid) begin
      r_buf_x[r_wcnt] <= bus.pt_x;
      r_buf_y[r_wcnt] <= bus.pt_y;
    end
  end
  // job sequencer with registered grant, engine-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_owner        <= '0;
      r_last         <= LW'(N_REQ - 1);
      r_wcnt         <= '0;
      r_scnt         <= '0;
      r_rcnt         <= '0;
      r_cool         <= '0;
      r_gnt          <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_in_x     <= '0;
      r_eng_in_y     <= '0;
      r_rsp_valid    <= '0;
      r_rsp_x        <= '0;
      r_rsp_y        <= '0;
      r_rsp_area     <= '0;
    end else begin
      r_gnt          <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_in_x     <= '0;
      r_eng_in_y     <= '0;
      r_rsp_valid    <= '0;
      r_rsp_x        <= '0;
      r_rsp_y        <= '0;
      r_rsp_area     <= '0;
      case (r_state)
        IDLE: if (|bus.req) begin
          r_owner <= w_win;
          r_last  <= w_win;
          r_gnt   <= N_REQ'(1) << w_win;
          r_state <= GRANT;
        end
        GRANT: begin
          r_wcnt  <= '0;
          r_state <= LOAD;
        end
        LOAD: if (bus.pt_valid) begin
          r_wcnt <= r_wcnt + 3'd1;
          if (r_wcnt == 3'd5) begin
            r_eng_in_valid <= 1'b1;
            r_eng_in_x     <= r_buf_x[0];
            r_eng_in_y     <= r_buf_y[0];
            r_scnt         <= 3'd1;
            r_state        <= SEND;
          end
        end
        SEND: if (r_scnt == 3'd6) r_state <= WAIT;
        else begin
          r_eng_in_valid <= 1'b1;
          r_eng_in_x     <= r_buf_x[r_scnt];
          r_eng_in_y     <= r_buf_y[r_scnt];
          r_scnt         <= r_scnt + 3'd1;
        end
        WAIT: if (bus.eng_out_valid) begin
          r_rsp_valid <= N_REQ'(1) << r_owner;
          r_rsp_x     <= bus.eng_out_x;
          r_rsp_y     <= bus.eng_out_y;
          r_rsp_area  <= bus.eng_out_area;
          r_rcnt      <= 3'd1;
          r_state     <= RET;
        end
        RET: if (!bus.eng_out_valid) begin
          r_cool  <= '0;
          r_state <= COOL;
        end else if (r_rcnt != 3'd6) begin
          r_rsp_valid <= N_REQ'(1) << r_owner;
          r_rsp_x     <= bus.eng_out_x;
          r_rsp_y     <= bus.eng_out_y;
          r_rsp_area  <= bus.eng_out_area;
          r_rcnt      <= r_rcnt + 3'd1;
        end
        COOL: if (r_cool == GW'(GAP - 1)) r_state <= IDLE;
        else r_cool <= r_cool + GW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef GF_SCHED_STATS_EN
  logic [8*N_REQ-1:0] r_job_cnt;
  // count a job when its sixth result beat is forwarded; 8-bit wrap is intended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_job_cnt <= '0;
    else if (r_state == RET && bus.eng_out_valid && r_rcnt == 3'd5)
      r_job_cnt[8*r_owner +: 8] <= r_job_cnt[8*r_owner +: 8] + 8'd1;
  end
  assign job_cnt = r_job_cnt;
`endif
  assign bus.gnt          = r_gnt;
  assign bus.eng_in_valid = r_eng_in_valid;
  assign bus.eng_in_x     = r_eng_in_x;
  assign bus.eng_in_y     = r_eng_in_y;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_x        = r_rsp_x;
  assign bus.rsp_y        = r_rsp_y;
  assign bus.rsp_area     = r_rsp_area;
  assign bus.busy         = r_state != IDLE;
endmodule

// File: tb/tb_gf_sched.sv
// tb_gf_sched: directed scheduler bench with a model engine and scoreboard queues for grants, engine beats and responses
module tb_gf_sched;
  localparam int N_REQ = 2;
  localparam int CW    = 10;
  localparam int AW    = 25;
  localparam int GAP   = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rsp = 0;
  logic mon_ok;
  logic [63:0] q_gnt [$];
  logic [63:0] q_eng [$];
  logic [63:0] q_rsp [$];
  logic [CW-1:0] px [8];
  logic [CW-1:0] py [8];
  gf_sched_if #(.N_REQ(N_REQ), .CW(CW), .AW(AW)) bus ();
`ifdef GF_SCHED_STATS_EN
  logic [8*N_REQ-1:0] job_cnt;
`endif
  gf_sched #(.N_REQ(N_REQ), .CW(CW), .AW(AW), .GAP(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef GF_SCHED_STATS_EN
    ,
    .job_cnt(job_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // scoreboard monitor plus per-cycle output invariants
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ok = (bus.eng_in_valid || {bus.eng_in_x, bus.eng_in_y} == '0) &&
               (|bus.rsp_valid || {bus.rsp_x, bus.rsp_y, bus.rsp_area} == '0) &&
               $onehot0(bus.gnt) && $onehot0(bus.rsp_valid) && !(|bus.gnt && |bus.rsp_valid) &&
               (bus.busy || (bus.gnt == '0 && !bus.eng_in_valid && bus.rsp_valid == '0));
      chk("inv", 64'(mon_ok), 64'd1);
      if (|bus.gnt) chk("gnt", 64'(bus.gnt), q_gnt.size() > 0 ? q_gnt.pop_front() : 64'd0);
      if (bus.eng_in_valid)
        chk("eng_in", 64'({bus.eng_in_x, bus.eng_in_y}), q_eng.size() > 0 ? q_eng.pop_front() : '1);
      if (|bus.rsp_valid)
        chk("rsp", 64'({bus.rsp_valid, bus.rsp_x, bus.rsp_y, bus.rsp_area}), q_rsp.size() > 0 ? q_rsp.pop_front() : '1);
    end
  end
  task automatic idle_inputs();
    bus.pt_valid = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.eng_out_valid = 1'b0;
    bus.eng_out_x = '0;
    bus.eng_out_y = '0;
    bus.eng_out_area = '0;
  endtask
  task automatic rand_pts();
    for (int k = 0; k < 8; k++) begin
      px[k] = CW'($urandom_range(0, 1023));
      py[k] = CW'($urandom_range(0, 1023));
    end
  endtask
  // one job: await grant, feed points, check the engine burst, play the engine result burst
  task automatic run_job(input int who, input int bub, input int npts, input int nbeats,
                         input logic [AW-1:0] area, input logic [N_REQ-1:0] req_after,
                         input int exp_wait, input bit chk_gap);
    int w;
    logic [N_REQ-1:0] oh;
    logic [CW-1:0] ex;
    logic [CW-1:0] ey;
    oh = N_REQ'(1) << who;
    q_gnt.push_back(64'(oh));
    w = 0;
    while (!(|bus.gnt) && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("gnt_seen", 64'(|bus.gnt), 64'd1);
    if (exp_wait > 0) chk("gnt_lat", 64'(w), 64'(exp_wait));
    if (chk_gap) chk("gap", 64'((cyc - last_rsp) inside {[GAP+1:GAP+2]}), 64'd1);
    bus.req = req_after;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bus.pt_valid = 1'b1;
      bus.pt_x = px[k];
      bus.pt_y = py[k];
      q_eng.push_back(64'({px[k], py[k]}));
      @(negedge clk);
      if (k < 5 && bub > 0) begin
        bus.pt_valid = 1'b0;
        repeat (bub) @(negedge clk);
      end
    end
    for (int i = 0; i < 7; i++) begin
      chk("burst", 64'(bus.eng_in_valid), 64'(i < 6));
      if (6 + i < npts) begin
        bus.pt_x = px[6+i];
        bus.pt_y = py[6+i];
      end else bus.pt_valid = 1'b0;
      @(negedge clk);
    end
    bus.pt_valid = 1'b0;
    if (nbeats == 0) return;
    repeat (2) @(negedge clk);
    for (int b = 0; b < nbeats; b++) begin
      ex = b < 6 ? px[5-b] : CW'(1023);
      ey = b < 6 ? py[5-b] : CW'(511);
      bus.eng_out_valid = 1'b1;
      bus.eng_out_x = ex;
      bus.eng_out_y = ey;
      bus.eng_out_area = area;
      if (b < 6) q_rsp.push_back(64'({oh, ex, ey, area}));
      @(negedge clk);
      chk("rsp_lat", 64'(bus.rsp_valid), b < 6 ? 64'(oh) : 64'd0);
      if (b < 6) last_rsp = cyc;
    end
    idle_inputs();
    @(negedge clk);
    chk("rsp_end", 64'(bus.rsp_valid), 64'd0);
  endtask
  initial begin
    idle_inputs();
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({bus.gnt, bus.eng_in_valid, bus.rsp_valid, bus.busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    px[0] = 0; py[0] = 0; px[1] = 4; py[1] = 0; px[2] = 4; py[2] = 3;
    px[3] = 0; py[3] = 3; px[4] = 2; py[4] = 5; px[5] = 1; py[5] = 1;
    bus.req = 2'b01;
    run_job(0, 0, 6, 6, 25'd14, 2'b00, 1, 1'b0);
    repeat (GAP + 2) @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    rand_pts();
    bus.req = 2'b10;
    run_job(1, 3, 6, 6, 25'd99, 2'b00, 1, 1'b0);
    repeat (GAP + 2) @(negedge clk);
    bus.req = 2'b11;
    rand_pts();
    run_job(0, 0, 6, 6, 25'd1000, 2'b11, 1, 1'b0);
    rand_pts();
    run_job(1, 0, 6, 6, 25'd2000, 2'b11, 0, 1'b1);
    rand_pts();
    run_job(0, 1, 6, 6, 25'd3000, 2'b11, 0, 1'b1);
    rand_pts();
    run_job(1, 0, 6, 6, 25'd4000, 2'b00, 0, 1'b1);
    repeat (GAP + 3) @(negedge clk);
    chk("cont_idle", 64'(bus.busy), 64'd0);
    rand_pts();
    bus.req = 2'b01;
    run_job(0, 1, 8, 7, 25'h1ABCDEF, 2'b00, 1, 1'b0);
    repeat (GAP + 2) @(negedge clk);
    bus.eng_out_valid = 1'b1;
    bus.eng_out_x = 10'h155;
    bus.eng_out_area = 25'd77;
    bus.pt_valid = 1'b1;
    bus.pt_x = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_idle", 64'({bus.rsp_valid, bus.eng_in_valid, bus.busy}), 64'd0);
    end
    idle_inputs();
    @(negedge clk);
    rand_pts();
    bus.req = 2'b01;
    run_job(0, 0, 6, 0, 25'd0, 2'b00, 1, 1'b0);
    chk("wait_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 64'({bus.gnt, bus.eng_in_valid, bus.rsp_valid, bus.busy}), 64'd0);
    chk("rst_mid_dat", 64'({bus.eng_in_x, bus.eng_in_y, bus.rsp_x, bus.rsp_y}), 64'd0);
    chk("rst_mid_area", 64'(bus.rsp_area), 64'd0);
    q_gnt.delete();
    q_eng.delete();
    q_rsp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_pts();
    bus.req = 2'b10;
    run_job(1, 0, 6, 6, 25'd321, 2'b00, 1, 1'b0);
    repeat (GAP + 2) @(negedge clk);
`ifdef GF_SCHED_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 257; j++) begin
      bus.req = 2'b01;
      run_job(0, 0, 6, 6, AW'(j), 2'b00, 1, 1'b0);
      repeat (GAP + 2) @(negedge clk);
    end
    chk("job_cnt0", 64'(job_cnt[7:0]), 64'd1);
    chk("job_cnt1", 64'(job_cnt[15:8]), 64'd0);
`endif
    chk("q_left", 64'(q_gnt.size() + q_eng.size() + q_rsp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
